imem_loadable: RTL and testbench
================================

# imem_loadable

Parametrised, software-loadable successor to the hard-coded instruction memory of the MIPS CPU datapath. It holds 2^ADDR_WIDTH instruction words and clears itself after reset. A sequential load port (auto-incrementing write pointer) lets the testbench or a boot loader stream a program in, replacing any compile-time initial contents. It sits between the PC register and the decode stage and serves word-addressed fetches with a fixed 1-cycle latency and a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 10, word-address width; DEPTH = 2^ADDR_WIDTH words
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- load_start  input  1  pulse: enter LOAD, clear write pointer and load_ovf
- load_valid  input  1  load_data valid this cycle (honoured only in LOAD)
- load_data  input  DATA_WIDTH  word to write at the write pointer
- load_stop  input  1  pulse: leave LOAD, return to RUN
- load_count  output  ADDR_WIDTH+1  words written since last load_start
- load_ovf  output  1  sticky: a write was attempted with the pointer at DEPTH
- fetch_req  input  1  fetch request
- fetch_addr  input  ADDR_WIDTH  word address
- fetch_ready  output  1  fetch port accepts requests (state RUN)
- fetch_valid  output  1  fetch_data valid this cycle
- fetch_data  output  DATA_WIDTH  fetched word
- busy  output  1  high in CLEAR or LOAD

## Operation
- States: CLEAR, RUN, LOAD. Outputs are decoded from the registered state.
- Reset (async, immediate): state=CLEAR, clear counter=0, write pointer=0, load_count=0, load_ovf=0, fetch_valid=0, fetch_data=0. busy=1, fetch_ready=0.
- CLEAR: writes 0 to mem[clear counter] each cycle and increments the counter. After writing DEPTH-1, the next state is RUN. CLEAR lasts exactly DEPTH cycles. load_* and fetch_req are ignored.
- RUN: fetch_ready=1, busy=0.
  - fetch_req accepted: fetch_data <= mem[fetch_addr] and fetch_valid <= 1 on the next edge.
  - No accepted request: fetch_valid <= 0 and fetch_data holds its last value.
  - load_start in RUN: next state is LOAD, pointer=0, load_count=0, load_ovf=0. A fetch_req in the same cycle is still accepted and returns the pre-load contents.
- LOAD: fetch_ready=0, busy=1.
  - load_valid with pointer < DEPTH: mem[pointer] <= load_data; pointer and load_count increment.
  - load_valid with pointer == DEPTH: no write, pointer saturates, load_ovf <= 1.
  - load_stop: next state is RUN. A load_valid in the same cycle is still written.
  - load_start in LOAD: restarts the load (pointer=0, count=0, ovf=0). If load_valid is also high, that word is written to address 0 and the pointer becomes 1.
  - load_start together with load_stop: load_stop wins.
- Locations not rewritten keep their previous contents; a load does not clear memory.
- load_count and load_ovf hold their values in RUN until the next load_start or reset.
- fetch_req while fetch_ready=0 is dropped, not queued; fetch_valid stays 0.

## Timing
- Fetch latency: 1 cycle, from the request edge to fetch_valid/fetch_data. The port is fully pipelined, one request per cycle; back-to-back requests give back-to-back valids.
- Load write latency: 1 cycle. A word written at edge N is fetchable by a request issued at edge N+2 or later, after load_stop has returned the state to RUN.
- fetch_ready falls on the edge that enters LOAD and rises on the edge that enters RUN.
- The read from mem is registered (synchronous RAM, inferrable as block RAM). There is no combinational path from fetch_addr to fetch_data.
- Reset asserted mid-LOAD or mid-fetch: the in-flight fetch_valid drops immediately, memory is re-cleared over DEPTH cycles, and the program must be reloaded.

## Test plan
- Reset with ADDR_WIDTH=4: busy=1 for exactly 16 cycles, then fetch_ready=1. Fetching addresses 0..15 returns 0 with fetch_valid one cycle after each request.
- Load 8 words (e.g. 0x1417_0C00..0x1417_0C03, then 0x1000_0000..0x1000_0003), then stop. Required: load_count=8, load_ovf=0. Fetches of addresses 0..7 back-to-back return the words in order on consecutive cycles; address 8 returns 0.
- Overflow, ADDR_WIDTH=4: stream 18 valid words. Required: load_count=16, load_ovf=1 after the 17th word, mem[0..15] holds the first 16 words.
- fetch_req held high during LOAD: fetch_valid stays 0. load_start with fetch_req in RUN: that one fetch returns the old word.
- Restart: load 5 words, pulse load_start, load 2 words, stop. Required: count=2, addresses 0..1 hold the new words, 2..4 keep the first load's words.
- Async rst pulsed mid-load, between clock edges: fetch_valid=0 and busy=1 immediately; after DEPTH cycles, all addresses read 0.

Source files
------------

// File: rtl/imem_loadable.sv
// Software-loadable instruction memory: self-clears after reset, accepts a streamed
// program through an auto-incrementing load port, and serves 1-cycle registered fetches.
module imem_loadable #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_stop,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_ovf,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_LOAD
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
  logic                    load_ovf_q, load_ovf_d;
  logic                    fetch_valid_q, fetch_valid_d;
  logic [DATA_WIDTH-1:0]   fetch_data_q, fetch_data_d;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [ADDR_WIDTH:0]     ptr_base;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    load_ovf_d    = load_ovf_q;
    fetch_valid_d = 1'b0;
    fetch_data_d  = fetch_data_q;
    mem_we        = 1'b0;
    mem_waddr     = '0;
    mem_wdata     = '0;
    ptr_base      = wr_ptr_q;

    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = S_RUN;
      end

      S_RUN: begin
        if (fetch_req) begin
          fetch_valid_d = 1'b1;
          fetch_data_d  = mem[fetch_addr];
        end
        if (load_start) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          load_ovf_d = 1'b0;
        end
      end

      S_LOAD: begin
        // A restart rebases the pointer so a word arriving with it lands at address 0.
        if (load_stop) begin
          state_d = S_RUN;
        end else if (load_start) begin
          ptr_base   = '0;
          wr_ptr_d   = '0;
          load_ovf_d = 1'b0;
        end
        if (load_valid) begin
          if (ptr_base != PTR_FULL) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_base[ADDR_WIDTH-1:0];
            mem_wdata = load_data;
            wr_ptr_d  = ptr_base + 1'b1;
          end else begin
            load_ovf_d = 1'b1;
          end
        end
      end

      default: state_d = S_CLEAR;
    endcase
  end

  // NOTE: the array has no reset so it maps onto block RAM; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_CLEAR;
      clr_cnt_q     <= '0;
      wr_ptr_q      <= '0;
      load_ovf_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      load_ovf_q    <= load_ovf_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
    end
  end

  assign load_count  = wr_ptr_q;
  assign load_ovf    = load_ovf_q;
  assign fetch_ready = (state_q == S_RUN);
  assign busy        = (state_q != S_RUN);
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Randomized self-checking bench for imem_loadable (ADDR_WIDTH=4) against an
// array-based model of memory contents, load pointer and overflow flag.
module tb_imem_loadable;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data  = '0;
  logic          load_stop  = 1'b0;
  logic [AW:0]   load_count;
  logic          load_ovf;
  logic          fetch_req  = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          busy;

  imem_loadable #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_stop  (load_stop),
    .load_count (load_count),
    .load_ovf   (load_ovf),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain array contents plus load bookkeeping.
  logic [DW-1:0] model [DEPTH];
  int            m_ptr;
  bit            m_ovf;
  logic [AW-1:0] fq [$];
  int            n_pass  = 0;
  int            n_total = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    m_ptr = 0;
    m_ovf = 0;
  endfunction

  function automatic void model_write(input logic [DW-1:0] w);
    if (m_ptr < DEPTH) begin
      model[m_ptr] = w;
      m_ptr++;
    end else begin
      m_ovf = 1;
    end
  endfunction

  task automatic drive_word(input logic [DW-1:0] w);
    load_valid = 1'b1;
    load_data  = w;
    step();
    model_write(w);
    load_valid = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    m_ptr = 0;
    m_ovf = 0;
  endtask

  task automatic stop_load(input string tag);
    load_stop = 1'b1;
    step();
    load_stop = 1'b0;
    n_total++;
    if (fetch_ready !== 1'b1 || busy !== 1'b0 || load_count !== (AW+1)'(m_ptr) || load_ovf !== m_ovf)
      $display("FAIL %s_stop ready=%b busy=%b count=%0d ovf=%b expected ready=1 busy=0 count=%0d ovf=%b",
               tag, fetch_ready, busy, load_count, load_ovf, m_ptr, m_ovf);
    else n_pass++;
  endtask

  // Issues the queued addresses back-to-back and checks each returns a cycle later.
  task automatic fetch_burst(input string tag);
    logic [AW-1:0] last;
    last = '0;
    for (int i = 0; i < fq.size(); i++) begin
      fetch_req  = 1'b1;
      fetch_addr = fq[i];
      last       = fq[i];
      step();
      n_total++;
      if (fetch_valid !== 1'b1 || fetch_data !== model[fq[i]])
        $display("FAIL %s addr=%0d valid=%b data=%h expected valid=1 data=%h",
                 tag, fq[i], fetch_valid, fetch_data, model[fq[i]]);
      else n_pass++;
    end
    fetch_req = 1'b0;
    step();
    n_total++;
    if (fetch_valid !== 1'b0 || fetch_data !== model[last])
      $display("FAIL %s_idle valid=%b data=%h expected valid=0 data=%h",
               tag, fetch_valid, fetch_data, model[last]);
    else n_pass++;
    fq.delete();
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    n_total++;
    if (n != DEPTH || fetch_ready !== 1'b1)
      $display("FAIL %s_clear_len cycles=%0d ready=%b expected cycles=%0d ready=1", tag, n, fetch_ready, DEPTH);
    else n_pass++;
  endtask

  task automatic test_reset();
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b1 || fetch_ready !== 1'b0 || fetch_valid !== 1'b0 || fetch_data !== '0 ||
        load_count !== '0 || load_ovf !== 1'b0)
      $display("FAIL reset_state busy=%b ready=%b valid=%b data=%h count=%0d ovf=%b expected 1 0 0 0 0 0",
               busy, fetch_ready, fetch_valid, fetch_data, load_count, load_ovf);
    else n_pass++;
    wait_clear("reset");
    for (int i = 0; i < DEPTH; i++) fq.push_back(AW'(i));
    fetch_burst("cleared_read");
  endtask

  task automatic test_load8();
    logic [DW-1:0] words [8];
    words = '{32'h1417_0C00, 32'h1417_0C01, 32'h1417_0C02, 32'h1417_0C03,
              32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003};
    start_load();
    n_total++;
    if (fetch_ready !== 1'b0 || busy !== 1'b1 || load_count !== '0)
      $display("FAIL load_enter ready=%b busy=%b count=%0d expected 0 1 0", fetch_ready, busy, load_count);
    else n_pass++;
    foreach (words[i]) drive_word(words[i]);
    stop_load("load8");
    for (int i = 0; i <= 8; i++) fq.push_back(AW'(i));
    fetch_burst("load8_read");
  endtask

  task automatic test_fetch_during_load();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 7));
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    load_start = 1'b0;
    n_total++;
    if (fetch_valid !== 1'b1 || fetch_data !== model[a] || fetch_ready !== 1'b0)
      $display("FAIL start_with_fetch valid=%b data=%h ready=%b expected valid=1 data=%h ready=0",
               fetch_valid, fetch_data, fetch_ready, model[a]);
    else n_pass++;
    m_ptr = 0;
    m_ovf = 0;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = AW'($urandom);
      drive_word($urandom);
      n_total++;
      if (fetch_valid !== 1'b0 || load_count !== (AW+1)'(m_ptr))
        $display("FAIL fetch_in_load valid=%b count=%0d expected valid=0 count=%0d", fetch_valid, load_count, m_ptr);
      else n_pass++;
    end
    fetch_req = 1'b0;
    stop_load("fetch_in_load");
    for (int i = 0; i < 5; i++) fq.push_back(AW'(i));
    fetch_burst("fetch_in_load_read");
  endtask

  task automatic test_overflow();
    start_load();
    for (int i = 0; i < 18; i++) begin
      drive_word($urandom);
      n_total++;
      if (load_count !== (AW+1)'(m_ptr) || load_ovf !== m_ovf)
        $display("FAIL overflow_word%0d count=%0d ovf=%b expected count=%0d ovf=%b",
                 i, load_count, load_ovf, m_ptr, m_ovf);
      else n_pass++;
    end
    stop_load("overflow");
    for (int i = 0; i < DEPTH; i++) fq.push_back(AW'(i));
    fetch_burst("overflow_read");
  endtask

  task automatic test_restart();
    logic [DW-1:0] w;
    start_load();
    for (int i = 0; i < 5; i++) drive_word($urandom);
    w = $urandom;
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = w;
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
    m_ptr = 0;
    m_ovf = 0;
    model_write(w);
    n_total++;
    if (load_count !== (AW+1)'(1))
      $display("FAIL restart_with_word count=%0d expected 1", load_count);
    else n_pass++;
    w = $urandom;
    load_valid = 1'b1;
    load_stop  = 1'b1;
    load_data  = w;
    step();
    load_valid = 1'b0;
    load_stop  = 1'b0;
    model_write(w);
    n_total++;
    if (load_count !== (AW+1)'(2) || fetch_ready !== 1'b1)
      $display("FAIL restart_stop count=%0d ready=%b expected count=2 ready=1", load_count, fetch_ready);
    else n_pass++;
    for (int i = 0; i < 5; i++) fq.push_back(AW'(i));
    fetch_burst("restart_read");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) fq.push_back(AW'($urandom));
    fetch_burst("b2b_random");
  endtask

  task automatic test_reset_mid();
    start_load();
    drive_word($urandom);
    drive_word($urandom);
    stop_load("pre_reset");
    fetch_req  = 1'b1;
    fetch_addr = AW'(1);
    step();
    fetch_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (fetch_valid !== 1'b0 || busy !== 1'b1 || fetch_ready !== 1'b0)
      $display("FAIL async_reset valid=%b busy=%b ready=%b expected valid=0 busy=1 ready=0",
               fetch_valid, busy, fetch_ready);
    else n_pass++;
    #3 rst = 1'b0;
    model_clear();
    wait_clear("mid_reset");
    for (int i = 0; i < DEPTH; i++) fq.push_back(AW'(i));
    fetch_burst("mid_reset_read");
  endtask

  initial begin
    test_reset();
    test_load8();
    test_fetch_during_load();
    test_overflow();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
